t16: RTL and testbench

T16 -- requirements
Module: t16

---
 rtl/t16_if.sv | 24 ++
 rtl/t16.sv | 117 +++++++++++
 tb/tb_t16.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/t16_if.sv
// Bus bundle between the t16 core (master) and its instruction/data memory (slave).
// state_dbg mirrors the core's EXEC/LOAD state for observation.
interface t16_if;
    logic [15:0] instr;
    logic [15:0] readdata;
    logic [4:0]  cpc;
    logic [15:0] writeaddr;
    logic [15:0] readaddr;
    logic        memwrite;
    logic        memreg;
    logic [15:0] writedata;
    logic [4:0]  nxtpc;
    logic        state_dbg;

    modport master (
        input  instr, readdata, cpc,
        output writeaddr, readaddr, memwrite, memreg, writedata, nxtpc, state_dbg
    );

    modport slave (
        output instr, readdata, cpc,
        input  writeaddr, readaddr, memwrite, memreg, writedata, nxtpc, state_dbg
    );
endinterface

// File: rtl/t16.sv
// t16: 16-bit, 16-register single-issue core with a 5-bit PC and two-cycle loads.
// Build option T16_HALT_EN: opcode F holds the PC; otherwise F is a NOP.
module t16 (
    input  logic   clk,
    input  logic   rst,
    t16_if.master  bus
);
    typedef enum logic {EXEC = 1'b0, LOAD = 1'b1} state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_BNZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [15:0] regs_q [16];
    logic [15:0] regs_d [16];

    logic [3:0]  op, rd, rs, rt;
    logic [7:0]  imm8;
    logic [4:0]  tgt;
    logic [15:0] rs_val, rt_val, rd_val;
    logic [4:0]  pc_inc;
    logic        memwrite_c, memreg_c;

    assign op     = bus.instr[15:12];
    assign rd     = bus.instr[11:8];
    assign rs     = bus.instr[7:4];
    assign rt     = bus.instr[3:0];
    assign imm8   = bus.instr[7:0];
    assign tgt    = bus.instr[4:0];
    assign rs_val = regs_q[rs];
    assign rt_val = regs_q[rt];
    assign rd_val = regs_q[rd];
    // Sequencing is based on the externally fed-back PC; 5-bit add wraps 31 -> 0.
    assign pc_inc = bus.cpc + 5'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        regs_d     = regs_q;
        memwrite_c = 1'b0;
        memreg_c   = 1'b0;
        if (state_q == LOAD) begin
            // The LD instruction is still presented, so rd names the load target.
            regs_d[rd] = bus.readdata;
            pc_d       = pc_inc;
            state_d    = EXEC;
        end else begin
            case (op)
                OP_NOP:  pc_d = pc_inc;
                OP_ADD:  begin regs_d[rd] = rs_val + rt_val;       pc_d = pc_inc; end
                OP_SUB:  begin regs_d[rd] = rs_val - rt_val;       pc_d = pc_inc; end
                OP_AND:  begin regs_d[rd] = rs_val & rt_val;       pc_d = pc_inc; end
                OP_OR:   begin regs_d[rd] = rs_val | rt_val;       pc_d = pc_inc; end
                OP_XOR:  begin regs_d[rd] = rs_val ^ rt_val;       pc_d = pc_inc; end
                OP_SHL:  begin regs_d[rd] = rs_val << rt_val[3:0]; pc_d = pc_inc; end
                OP_SHR:  begin regs_d[rd] = rs_val >> rt_val[3:0]; pc_d = pc_inc; end
                OP_LDI:  begin regs_d[rd] = {8'h00, imm8};         pc_d = pc_inc; end
                OP_ADDI: begin regs_d[rd] = rd_val + {{8{imm8[7]}}, imm8}; pc_d = pc_inc; end
                OP_LD: begin
                    memreg_c = 1'b1;
                    state_d  = LOAD;
                end
                OP_ST: begin
                    memwrite_c = 1'b1;
                    pc_d       = pc_inc;
                end
                OP_JMP:  pc_d = tgt;
                OP_BZ:   pc_d = (rd_val == 16'h0000) ? tgt : pc_inc;
                OP_BNZ:  pc_d = (rd_val != 16'h0000) ? tgt : pc_inc;
                OP_HALT: begin
`ifdef T16_HALT_EN
                    pc_d = pc_q;
`else
                    pc_d = pc_inc;
`endif
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EXEC;
            pc_q    <= 5'd0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Strobes are gated by rst so an abandoned load or a ST at address 0 stays silent.
    assign bus.memwrite  = memwrite_c & ~rst;
    assign bus.memreg    = memreg_c & ~rst;
    assign bus.readaddr  = rs_val;
    assign bus.writeaddr = rs_val;
    assign bus.writedata = rd_val;
    assign bus.nxtpc     = pc_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_t16.sv
// Bench for t16: program memory + data memory around the core, an ISA-level
// reference model feeding an expected-event queue, and a monitor that pops on strobes.
module tb_t16;
  logic clk;
  logic rst;
  t16_if bus ();

  t16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memories ----------------
  logic [15:0] imem [32];
  logic [15:0] dmem [256];
  logic        mem_init;

  assign bus.instr = imem[bus.nxtpc];
  assign bus.cpc   = bus.nxtpc;

  function automatic logic [15:0] init_word(input int i);
    return 16'(i * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
    end else begin
      if (bus.memwrite) dmem[bus.writeaddr[7:0]] <= bus.writedata;
      if (bus.memreg) bus.readdata <= dmem[bus.readaddr[7:0]];
    end
  end

  // ---------------- scoreboard ----------------
  // event = {is_load, pc, address, store_data (0 for loads)}
  logic [37:0] exp_q [$];
  int n_checks;
  int n_pass;

  task automatic check(input string name, input logic [37:0] got, input logic [37:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [37:0] got;
    if (rst) begin
      if (bus.memwrite || bus.memreg)
        check("strobe_in_reset", {36'h0, bus.memwrite, bus.memreg}, 38'h0);
    end else if (bus.memwrite || bus.memreg) begin
      if (bus.memwrite && bus.memreg) check("both_strobes", 38'h3, 38'h1);
      got = {bus.memreg, bus.nxtpc, bus.memreg ? bus.readaddr : bus.writeaddr,
             bus.memreg ? 16'h0000 : bus.writedata};
      if (exp_q.size() == 0) check("unexpected_event", got, 38'h0);
      else check("mem_event", got, exp_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] mr [16];
  logic [15:0] mm [256];
  logic [4:0]  mpc;

  task automatic model_reset_regs();
    for (int i = 0; i < 16; i++) mr[i] = 16'h0000;
    mpc = 5'd0;
  endtask

  task automatic model_run(input int k, output int cyc);
    logic [15:0] ins, a, b, d;
    logic [3:0]  op, rd;
    logic [4:0]  nxt;
    cyc = 0;
    for (int n = 0; n < k; n++) begin
      ins = imem[mpc];
      op  = ins[15:12];
      rd  = ins[11:8];
      a   = mr[ins[7:4]];
      b   = mr[ins[3:0]];
      d   = mr[rd];
      nxt = mpc + 5'd1;
      cyc += 1;
      case (op)
        4'h1: mr[rd] = a + b;
        4'h2: mr[rd] = a - b;
        4'h3: mr[rd] = a & b;
        4'h4: mr[rd] = a | b;
        4'h5: mr[rd] = a ^ b;
        4'h6: mr[rd] = 16'((32'(a) * (32'd1 << b[3:0])) % 65536);
        4'h7: mr[rd] = 16'(32'(a) / (32'd1 << b[3:0]));
        4'h8: mr[rd] = {8'h00, ins[7:0]};
        4'h9: mr[rd] = 16'(int'(d) + int'($signed(ins[7:0])));
        4'hA: begin
          exp_q.push_back({1'b1, mpc, a, 16'h0000});
          mr[rd] = mm[a[7:0]];
          cyc += 1;
        end
        4'hB: begin
          exp_q.push_back({1'b0, mpc, a, d});
          mm[a[7:0]] = d;
        end
        4'hC: nxt = ins[4:0];
        4'hD: if (d == 16'h0000) nxt = ins[4:0];
        4'hE: if (d != 16'h0000) nxt = ins[4:0];
        4'hF: begin
`ifdef T16_HALT_EN
          nxt = mpc;
`endif
        end
        default: ;
      endcase
      mpc = nxt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 32; a++) imem[a] = 16'h0000;
  endtask

  // Holds reset across one edge (memory init), then releases with the model reset.
  task automatic start_prog();
    rst = 1'b1;
    mem_init = 1'b1;
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    model_reset_regs();
    for (int i = 0; i < 256; i++) mm[i] = init_word(i);
    rst = 1'b0;
  endtask

  // Replace the program with ST Ri,[R0] sequences so each register appears on writedata.
  task automatic probe_regs();
    int c;
    logic [4:0] off;
    for (int a = 0; a < 32; a++) begin
      off = 5'(a) - mpc;
      imem[a] = {4'hB, off[3:0], 8'h00};
    end
    model_run(16, c);
    run_cycles(c);
    check("queue_drained", 38'(exp_q.size()), 38'h0);
  endtask

  task automatic run_prog(input string name, input int k, input logic [4:0] exp_pc, input bit use_pc);
    int c;
    start_prog();
    model_run(k, c);
    run_cycles(c);
    check({name, "_pc_model"}, {33'h0, bus.nxtpc}, {33'h0, mpc});
    if (use_pc) check({name, "_pc"}, {33'h0, bus.nxtpc}, {33'h0, exp_pc});
    probe_regs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    n_checks = 0;
    n_pass   = 0;
    mem_init = 1'b0;
    rst      = 1'b1;
    for (int a = 0; a < 32; a++) imem[a] = 16'hB000;
    #1;
    check("reset_nxtpc",    {33'h0, bus.nxtpc},   38'h0);
    check("reset_memwrite", {37'h0, bus.memwrite}, 38'h0);
    check("reset_memreg",   {37'h0, bus.memreg},  38'h0);
    check("reset_state",    {37'h0, bus.state_dbg}, 38'h0);
    @(posedge clk);
    #1;

    // LDI R1,5; LDI R2,3; ADD R3,R1,R2
    clear_imem();
    imem[0] = 16'h8105; imem[1] = 16'h8203; imem[2] = 16'h1312;
    run_prog("add", 3, 5'd3, 1'b1);

    // LDI R1,7; LDI R2,2; ST R1,[R2]; LD R4,[R2]
    clear_imem();
    imem[0] = 16'h8107; imem[1] = 16'h8202; imem[2] = 16'hB120; imem[3] = 16'hA420;
    run_prog("st_ld", 4, 5'd4, 1'b1);

    // LDI R5,0; BZ R5,0x10; @0x10 BNZ R5,0x10
    clear_imem();
    imem[0] = 16'h8500; imem[1] = 16'hD510; imem[16] = 16'hE510;
    run_prog("branch", 3, 5'd17, 1'b1);

    // ADDI R6,0xFF; LDI R7,1; SUB R8,R0,R7; JMP 31; @31 NOP
    clear_imem();
    imem[0] = 16'h96FF; imem[1] = 16'h8701; imem[2] = 16'h2807; imem[3] = 16'hC01F;
    run_prog("wrap", 5, 5'd0, 1'b1);

    // HALT at address 4, then ten more steps
    clear_imem();
    imem[4] = 16'hF000;
`ifdef T16_HALT_EN
    run_prog("halt", 14, 5'd4, 1'b1);
`else
    run_prog("halt", 14, 5'd14, 1'b1);
`endif

    // Reset asserted while the LD sits in LOAD
    clear_imem();
    imem[0] = 16'h8205; imem[1] = 16'h8409; imem[2] = 16'hA420;
    start_prog();
    model_run(3, c);
    run_cycles(3);
    check("mid_ld_state", {37'h0, bus.state_dbg}, 38'h1);
    rst = 1'b1;
    #1;
    check("mid_ld_nxtpc",  {33'h0, bus.nxtpc},    38'h0);
    check("mid_ld_memreg", {37'h0, bus.memreg},   38'h0);
    check("mid_ld_state0", {37'h0, bus.state_dbg}, 38'h0);
    check("mid_ld_regs",   {22'h0, bus.writeaddr}, 38'h0);
    model_reset_regs();
    @(posedge clk);
    #1;
    for (int a = 0; a < 32; a++) imem[a] = {4'hB, a[3:0], 8'h00};
    rst = 1'b0;
    probe_regs();

    // Random programs
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < 32; a++)
        imem[a] = {4'($urandom_range(0, 15)), 12'($urandom)};
      run_prog("random", $urandom_range(10, 50), 5'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
